// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Memory-mapped interrupt controller aggregating up to 32 sources
//            into a single irq line. Per-source pending latch, enable mask and
//            edge/level trigger select. Registers: PENDING (W1C), ENABLE,
//            TRIGGER, CLAIM (lowest-numbered active source, 1-based).
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int N_SOURCES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SOURCES-1:0] src,
  input  logic                 valid,
  output logic                 ready,
  input  logic [31:0]          address,
  input  logic [3:0]           wstrobe,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 irq
);

  localparam logic [1:0] C_REG_PENDING = 2'd0;
  localparam logic [1:0] C_REG_ENABLE  = 2'd1;
  localparam logic [1:0] C_REG_TRIGGER = 2'd2;
  localparam logic [1:0] C_REG_CLAIM   = 2'd3;

  logic [N_SOURCES-1:0] pending_q, pending_d;
  logic [N_SOURCES-1:0] enable_q,  enable_d;
  logic [N_SOURCES-1:0] trigger_q, trigger_d;
  logic [N_SOURCES-1:0] src_prev_q;
  logic                 ready_q;
  logic [31:0]          rdata_q,   rdata_d;
  logic                 irq_q;

  logic                 w_commit;
  logic                 w_write;
  logic [1:0]           w_sel;
  logic [31:0]          w_bytemask;
  logic [N_SOURCES-1:0] w_mask;
  logic [N_SOURCES-1:0] w_wval;
  logic [N_SOURCES-1:0] w_clear;
  logic [N_SOURCES-1:0] w_active;
  logic [31:0]          w_pend32, w_en32, w_trig32, w_claim, w_read_val;
  logic                 unused_bits;

  // A request is accepted on the edge where ready rises; the second cycle of
  // a held request (ready already high) is not a new transaction.
  assign w_commit   = valid && !ready_q;
  assign w_write    = w_commit && (wstrobe != 4'b0000);
  assign w_sel      = address[3:2];
  assign w_bytemask = {{8{wstrobe[3]}}, {8{wstrobe[2]}}, {8{wstrobe[1]}}, {8{wstrobe[0]}}};
  assign w_mask     = w_bytemask[N_SOURCES-1:0];
  assign w_wval     = wdata[N_SOURCES-1:0];
  assign w_active   = pending_q & enable_q;

  // Only address[3:2] and the low N_SOURCES data bits are meaningful.
  assign unused_bits = ^{address, wdata, w_bytemask};

  // Next-state for the control registers and pending latches.
  always_comb begin
    enable_d  = enable_q;
    trigger_d = trigger_q;
    w_clear   = '0;
    if (w_write) begin
      case (w_sel)
        C_REG_PENDING: w_clear   = w_wval & w_mask;
        C_REG_ENABLE:  enable_d  = (enable_q  & ~w_mask) | (w_wval & w_mask);
        C_REG_TRIGGER: trigger_d = (trigger_q & ~w_mask) | (w_wval & w_mask);
        default:       ;
      endcase
    end
    // Level sources track the line; edge sources latch a rising edge, and a
    // new edge beats a simultaneous W1C so no interrupt is ever lost.
    pending_d = (trigger_q & src)
              | (~trigger_q & ((pending_q & ~w_clear) | (src & ~src_prev_q)));
  end

  // Zero-extended register views and CLAIM priority encoder (lowest wins).
  always_comb begin
    w_pend32 = '0;
    w_en32   = '0;
    w_trig32 = '0;
    w_pend32[N_SOURCES-1:0] = pending_q;
    w_en32[N_SOURCES-1:0]   = enable_q;
    w_trig32[N_SOURCES-1:0] = trigger_q;
    w_claim = '0;
    for (int i = N_SOURCES - 1; i >= 0; i--) begin
      if (w_active[i]) w_claim = 32'(i + 1);
    end
  end

  // Read mux; a write acknowledges with zero data.
  always_comb begin
    case (w_sel)
      C_REG_PENDING: w_read_val = w_pend32;
      C_REG_ENABLE:  w_read_val = w_en32;
      C_REG_TRIGGER: w_read_val = w_trig32;
      C_REG_CLAIM:   w_read_val = w_claim;
      default:       w_read_val = '0;
    endcase
    rdata_d = (w_commit && (wstrobe == 4'b0000)) ? w_read_val : '0;
  end

  // State update; src_prev tracks src even in reset to suppress false edges.
  always_ff @(posedge clk) begin
    src_prev_q <= src;
    if (reset) begin
      pending_q <= '0;
      enable_q  <= '0;
      trigger_q <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      trigger_q <= trigger_d;
      ready_q   <= w_commit;
      rdata_q   <= rdata_d;
      irq_q     <= |w_active;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Directed vector bench for irq_controller (N_SOURCES = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  irq_controller #(.N_SOURCES(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .valid   (valid),
    .ready   (ready),
    .address (address),
    .wstrobe (wstrobe),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  src;
    logic [1:0]  reg_sel;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus transaction; waits (bounded) for ready and returns rdata.
  task automatic bus(input logic [1:0] sel, input logic [3:0] ws,
                     input logic [31:0] wd, output logic [31:0] rd);
    int n;
    valid   = 1'b1;
    address = {28'h0, sel, 2'b00};
    wstrobe = ws;
    wdata   = wd;
    n = 0;
    tick();
    while (!ready && n < 4) begin
      tick();
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL bus_timeout: ready=%0b expected 1", ready);
    end
    rd      = rdata;
    valid   = 1'b0;
    wstrobe = 4'b0000;
  endtask

  vec_t vecs[26];
  logic [31:0] rd;

  initial begin
    // {src, reg, wstrb, wdata, exp_rdata, exp_irq}
    // Edge mode basic
    vecs[0]  = '{8'h00, 2'd1, 4'hF, 32'h01, 32'h0, 1'b0};
    vecs[1]  = '{8'h01, 2'd0, 4'h0, 32'h00, 32'h01, 1'b1};
    vecs[2]  = '{8'h00, 2'd3, 4'h0, 32'h00, 32'h01, 1'b1};
    vecs[3]  = '{8'h00, 2'd0, 4'hF, 32'h01, 32'h0, 1'b0};
    vecs[4]  = '{8'h00, 2'd3, 4'h0, 32'h00, 32'h0, 1'b0};
    // Masking
    vecs[5]  = '{8'h00, 2'd1, 4'hF, 32'h00, 32'h0, 1'b0};
    vecs[6]  = '{8'h08, 2'd0, 4'h0, 32'h00, 32'h08, 1'b0};
    vecs[7]  = '{8'h00, 2'd1, 4'hF, 32'h08, 32'h0, 1'b1};
    vecs[8]  = '{8'h00, 2'd0, 4'hF, 32'h08, 32'h0, 1'b0};
    // Priority
    vecs[9]  = '{8'h00, 2'd1, 4'h1, 32'hFF, 32'h0, 1'b0};
    vecs[10] = '{8'h24, 2'd3, 4'h0, 32'h00, 32'h03, 1'b1};
    vecs[11] = '{8'h00, 2'd0, 4'hF, 32'h04, 32'h0, 1'b1};
    vecs[12] = '{8'h00, 2'd3, 4'h0, 32'h00, 32'h06, 1'b1};
    vecs[13] = '{8'h00, 2'd0, 4'hF, 32'h20, 32'h0, 1'b0};
    vecs[14] = '{8'h00, 2'd3, 4'h0, 32'h00, 32'h0, 1'b0};
    // Level mode
    vecs[15] = '{8'h00, 2'd2, 4'hF, 32'h10, 32'h0, 1'b0};
    vecs[16] = '{8'h00, 2'd1, 4'hF, 32'h10, 32'h0, 1'b0};
    vecs[17] = '{8'h10, 2'd0, 4'h0, 32'h00, 32'h10, 1'b1};
    vecs[18] = '{8'h10, 2'd0, 4'hF, 32'h10, 32'h0, 1'b1};
    vecs[19] = '{8'h10, 2'd0, 4'h0, 32'h00, 32'h10, 1'b1};
    // Byte masking and out-of-range bits (src[4] low -> level pending drops)
    vecs[20] = '{8'h00, 2'd1, 4'h1, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[21] = '{8'h00, 2'd1, 4'h0, 32'h00, 32'hFF, 1'b0};
    vecs[22] = '{8'h00, 2'd1, 4'hE, 32'h00000000, 32'h0, 1'b0};
    vecs[23] = '{8'h00, 2'd1, 4'h0, 32'h00, 32'hFF, 1'b0};
    vecs[24] = '{8'h00, 2'd3, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[25] = '{8'h00, 2'd2, 4'hF, 32'h00, 32'h0, 1'b0};

    reset = 1'b1; src = 8'h00; valid = 1'b0; address = '0; wstrobe = '0; wdata = '0;
    tick(); tick();
    chk("reset_ready", {31'b0, ready}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq",   {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 26; i++) begin
      src = vecs[i].src;
      tick();
      bus(vecs[i].reg_sel, vecs[i].wstrb, vecs[i].wdata, rd);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      tick();
      chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Level mode release timing: pending drops at the edge sampling src low,
    // irq follows one edge later. Re-arm source 4 in level mode first.
    bus(2'd2, 4'hF, 32'h10, rd);
    bus(2'd1, 4'hF, 32'h10, rd);
    src = 8'h10;
    tick(); tick();
    chk("lvl_irq_high", {31'b0, irq}, 32'h1);
    src = 8'h00;
    tick();
    chk("lvl_irq_lag", {31'b0, irq}, 32'h1);
    tick();
    chk("lvl_irq_low", {31'b0, irq}, 32'h0);
    bus(2'd0, 4'h0, 32'h0, rd);
    chk("lvl_pending_zero", rd, 32'h0);
    bus(2'd2, 4'hF, 32'h00, rd);

    // Set-versus-clear collision on source 1 (edge mode, enabled).
    bus(2'd1, 4'hF, 32'h02, rd);
    src = 8'h02; tick();
    src = 8'h00; tick(); tick();
    chk("coll_irq_before", {31'b0, irq}, 32'h1);
    src = 8'h02;
    bus(2'd0, 4'hF, 32'h02, rd);
    src = 8'h00;
    tick();
    chk("coll_irq_after", {31'b0, irq}, 32'h1);
    bus(2'd0, 4'h0, 32'h0, rd);
    chk("coll_pending", rd, 32'h02);
    bus(2'd0, 4'hF, 32'h02, rd);
    tick();
    chk("coll_cleared_irq", {31'b0, irq}, 32'h0);

    // Reset during an in-flight write, with all sources held high.
    bus(2'd1, 4'hF, 32'hFF, rd);
    src     = 8'hFF;
    reset   = 1'b1;
    valid   = 1'b1;
    address = 32'h4;
    wstrobe = 4'hF;
    wdata   = 32'hFF;
    tick();
    chk("rst_ready0", {31'b0, ready}, 32'h0);
    tick();
    chk("rst_ready1", {31'b0, ready}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    valid = 1'b0; wstrobe = 4'h0;
    reset = 1'b0;
    tick(); tick();
    chk("post_rst_irq", {31'b0, irq}, 32'h0);
    bus(2'd0, 4'h0, 32'h0, rd);
    chk("post_rst_pending", rd, 32'h0);
    bus(2'd1, 4'h0, 32'h0, rd);
    chk("post_rst_enable", rd, 32'h0);
    bus(2'd2, 4'h0, 32'h0, rd);
    chk("post_rst_trigger", rd, 32'h0);
    // Edge mode with src held high: enabling must not create an interrupt.
    bus(2'd1, 4'hF, 32'hFF, rd);
    tick(); tick();
    chk("post_rst_no_edge_irq", {31'b0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
